// File: rtl/uart_bus_host.sv
`default_nettype none
// ============================================================================
// Module   : uart_bus_host
// Purpose  : Bus initiator for uart_top. It polls the status register, writes
//            buffered TX bytes and reads RX bytes out onto a valid/ready stream.
// Option   : UART_HOST_POLL_EN adds a periodic status poll every POLL_CYC clocks.
// Revision : 1.0
// ============================================================================
module uart_bus_host #(
  parameter int         ACC_CYC     = 2,
  parameter logic [2:0] TX_ADDR     = 3'd0,
  parameter logic [2:0] RX_ADDR     = 3'd0,
  parameter logic [2:0] STAT_ADDR   = 3'd5,
  parameter int         RXRDY_BIT   = 0,
  parameter int         TXEMPTY_BIT = 5,
  parameter int         POLL_CYC    = 1000
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] addr_o,
  output logic       cs_o,
  output logic       nrw_o,
  output logic [7:0] datin_o,
  input  logic [7:0] datout_i,
  input  logic       int_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i
);

  localparam int               c_cnt_w    = (ACC_CYC > 1) ? $clog2(ACC_CYC) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(ACC_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_STAT_ACC = 3'd1,
    S_STAT_GAP = 3'd2,
    S_RX_ACC   = 3'd3,
    S_RX_GAP   = 3'd4,
    S_TX_ACC   = 3'd5,
    S_TX_GAP   = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic [2:0]         addr_q, addr_d;
  logic               cs_q, cs_d;
  logic               nrw_q, nrw_d;
  logic [7:0]         datin_q, datin_d;
  logic [7:0]         samp_q, samp_d;
  logic [7:0]         tx_buf_q, tx_buf_d;
  logic               tx_ready_q, tx_ready_d;
  logic [7:0]         rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;

  logic w_poll_pend;
  logic w_int_req;
  logic w_idle_start;
  logic w_acc_last;

  // int is level-sensitive and masked while a received byte is still unconsumed
  assign w_int_req    = int_i & ~rx_valid_q;
  assign w_idle_start = (state_q == S_IDLE) & (w_int_req | ~tx_ready_q | w_poll_pend);
  assign w_acc_last   = (cnt_q == c_cnt_last);

`ifdef UART_HOST_POLL_EN
  logic [11:0] poll_cnt_q;
  logic        poll_pend_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      poll_cnt_q  <= 12'd0;
      poll_pend_q <= 1'b0;
    end else if (poll_cnt_q == 12'(POLL_CYC - 1)) begin
      poll_cnt_q  <= 12'd0;
      poll_pend_q <= 1'b1;
    end else begin
      poll_cnt_q <= poll_cnt_q + 12'd1;
      if (w_idle_start) begin
        poll_pend_q <= 1'b0;
      end
    end
  end

  assign w_poll_pend = poll_pend_q;
`else
  assign w_poll_pend = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= 3'd0;
      cs_q       <= 1'b0;
      nrw_q      <= 1'b0;
      datin_q    <= 8'd0;
      samp_q     <= 8'd0;
      tx_buf_q   <= 8'd0;
      tx_ready_q <= 1'b1;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      cs_q       <= cs_d;
      nrw_q      <= nrw_d;
      datin_q    <= datin_d;
      samp_q     <= samp_d;
      tx_buf_q   <= tx_buf_d;
      tx_ready_q <= tx_ready_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    cs_d       = cs_q;
    nrw_d      = nrw_q;
    datin_d    = datin_q;
    samp_d     = samp_q;
    tx_buf_d   = tx_buf_q;
    tx_ready_d = tx_ready_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;

    // Stream handshakes run independently of the bus FSM
    if (tx_valid_i && tx_ready_q) begin
      tx_buf_d   = tx_data_i;
      tx_ready_d = 1'b0;
    end
    if (rx_valid_q && rx_ready_i) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (w_idle_start) begin
          state_d = S_STAT_ACC;
          cs_d    = 1'b1;
          addr_d  = STAT_ADDR;
          nrw_d   = 1'b0;
          datin_d = 8'd0;
          cnt_d   = '0;
        end
      end

      S_STAT_ACC: begin
        if (w_acc_last) begin
          cs_d    = 1'b0;
          samp_d  = datout_i;
          state_d = S_STAT_GAP;
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end

      S_STAT_GAP: begin
        // RX drains first so uart_top's receiver does not overrun behind a slow TX
        if (samp_q[RXRDY_BIT] && !rx_valid_q) begin
          state_d = S_RX_ACC;
          cs_d    = 1'b1;
          addr_d  = RX_ADDR;
          nrw_d   = 1'b0;
          datin_d = 8'd0;
          cnt_d   = '0;
        end else if (!tx_ready_q && samp_q[TXEMPTY_BIT]) begin
          state_d = S_TX_ACC;
          cs_d    = 1'b1;
          addr_d  = TX_ADDR;
          nrw_d   = 1'b1;
          datin_d = tx_buf_q;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RX_ACC: begin
        if (w_acc_last) begin
          cs_d    = 1'b0;
          samp_d  = datout_i;
          state_d = S_RX_GAP;
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end

      S_RX_GAP: begin
        rx_data_d  = samp_q;
        rx_valid_d = 1'b1;
        state_d    = S_IDLE;
      end

      S_TX_ACC: begin
        if (w_acc_last) begin
          cs_d    = 1'b0;
          state_d = S_TX_GAP;
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end

      S_TX_GAP: begin
        tx_ready_d = 1'b1;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cs_d    = 1'b0;
      end
    endcase
  end

  assign addr_o     = addr_q;
  assign cs_o       = cs_q;
  assign nrw_o      = nrw_q;
  assign datin_o    = datin_q;
  assign tx_ready_o = tx_ready_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;

endmodule
`default_nettype wire
